// File: rtl/br_resolve.sv
// Branch resolution unit: in-order queue of fetch-time predictions, compared
// against execute outcomes; drives predictor update, PC redirect and stats.
module br_resolve #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fetch_push_i,
   input  logic [31:0] fetch_pc_i,
   input  logic        fetch_take_i,
   input  logic [31:0] fetch_target_i,
   input  logic [1:0]  fetch_index_i,
   input  logic        ex_valid_i,
   input  logic        ex_taken_i,
   input  logic [31:0] ex_target_i,
   output logic        q_full_o,
   output logic        q_empty_o,
   output logic        upd_br_o,
   output logic        upd_taken_o,
   output logic        upd_correct_o,
   output logic [31:0] upd_target_o,
   output logic [1:0]  upd_index_o,
   output logic        redirect_o,
   output logic [31:0] redirect_pc_o,
   output logic [31:0] stat_branches_o,
   output logic [31:0] stat_mispredicts_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);

   logic [31:0]   pc_q     [DEPTH];
   logic          take_q   [DEPTH];
   logic [31:0]   target_q [DEPTH];
   logic [1:0]    index_q  [DEPTH];

   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;

   logic          upd_br_q, upd_taken_q, upd_correct_q, redirect_q;
   logic [31:0]   upd_target_q, redirect_pc_q;
   logic [1:0]    upd_index_q;
   logic [31:0]   stat_br_q, stat_mis_q;

   logic          pop, mispredict, push_ok;
   logic [31:0]   head_pc, head_target;
   logic          head_take;
   logic [1:0]    head_index;

   assign q_full_o  = (count_q == CNT_DEPTH);
   assign q_empty_o = (count_q == '0);

   assign head_pc     = pc_q[rd_ptr_q];
   assign head_take   = take_q[rd_ptr_q];
   assign head_target = target_q[rd_ptr_q];
   assign head_index  = index_q[rd_ptr_q];

   // Resolve the oldest entry; a mispredict makes every younger entry (and any
   // same-cycle push) wrong-path, so the push is suppressed.
   always_comb begin
      pop        = ex_valid_i && !q_empty_o;
      mispredict = pop && ((ex_taken_i != head_take) ||
                           (ex_taken_i && head_take && (ex_target_i != head_target)));
      push_ok    = fetch_push_i && (!q_full_o || pop) && !mispredict;
   end

   // Next pointer/count values, with flush taking priority on mispredict.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (mispredict) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (pop)     rd_ptr_d = rd_ptr_q + PTR_ONE;
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   // Queue payload storage; contents are only meaningful while counted.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         pc_q[wr_ptr_q]     <= fetch_pc_i;
         take_q[wr_ptr_q]   <= fetch_take_i;
         target_q[wr_ptr_q] <= fetch_target_i;
         index_q[wr_ptr_q]  <= fetch_index_i;
      end
   end

   // Queue control state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Registered predictor update, redirect and statistics; data fields hold
   // between strobes.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         upd_br_q      <= 1'b0;
         upd_taken_q   <= 1'b0;
         upd_correct_q <= 1'b0;
         upd_target_q  <= '0;
         upd_index_q   <= '0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         stat_br_q     <= '0;
         stat_mis_q    <= '0;
      end else begin
         upd_br_q   <= pop;
         redirect_q <= mispredict;
         if (pop) begin
            upd_taken_q   <= ex_taken_i;
            upd_correct_q <= !mispredict;
            upd_target_q  <= ex_target_i;
            upd_index_q   <= head_index;
            stat_br_q     <= stat_br_q + 32'd1;
         end
         if (mispredict) begin
            redirect_pc_q <= ex_taken_i ? ex_target_i : (head_pc + 32'd4);
            stat_mis_q    <= stat_mis_q + 32'd1;
         end
      end
   end

   assign upd_br_o           = upd_br_q;
   assign upd_taken_o        = upd_taken_q;
   assign upd_correct_o      = upd_correct_q;
   assign upd_target_o       = upd_target_q;
   assign upd_index_o        = upd_index_q;
   assign redirect_o         = redirect_q;
   assign redirect_pc_o      = redirect_pc_q;
   assign stat_branches_o    = stat_br_q;
   assign stat_mispredicts_o = stat_mis_q;

endmodule

// File: tb/tb_br_resolve.sv
// Self-checking bench for br_resolve: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_br_resolve;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fetch_push = 1'b0;
   logic [31:0] fetch_pc = '0;
   logic        fetch_take = 1'b0;
   logic [31:0] fetch_target = '0;
   logic [1:0]  fetch_index = '0;
   logic        ex_valid = 1'b0;
   logic        ex_taken = 1'b0;
   logic [31:0] ex_target = '0;
   logic        q_full, q_empty, upd_br, upd_taken, upd_correct, redirect;
   logic [31:0] upd_target, redirect_pc, stat_branches, stat_mispredicts;
   logic [1:0]  upd_index;

   int errors = 0;
   int checks = 0;

   br_resolve #(.DEPTH(DEPTH)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .fetch_push_i(fetch_push), .fetch_pc_i(fetch_pc), .fetch_take_i(fetch_take),
      .fetch_target_i(fetch_target), .fetch_index_i(fetch_index),
      .ex_valid_i(ex_valid), .ex_taken_i(ex_taken), .ex_target_i(ex_target),
      .q_full_o(q_full), .q_empty_o(q_empty),
      .upd_br_o(upd_br), .upd_taken_o(upd_taken), .upd_correct_o(upd_correct),
      .upd_target_o(upd_target), .upd_index_o(upd_index),
      .redirect_o(redirect), .redirect_pc_o(redirect_pc),
      .stat_branches_o(stat_branches), .stat_mispredicts_o(stat_mispredicts)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference model: in-flight predictions as a queue in program order.
   typedef struct packed {
      logic [31:0] pc;
      logic        take;
      logic [31:0] target;
      logic [1:0]  index;
   } pred_t;

   pred_t       mq[$];
   pred_t       mh;
   logic        m_pop, m_mis, m_acc;
   logic        m_upd_br = 1'b0, m_upd_taken = 1'b0, m_upd_correct = 1'b0, m_redirect = 1'b0;
   logic [31:0] m_upd_target = '0, m_redirect_pc = '0, m_br = '0, m_mis_cnt = '0;
   logic [1:0]  m_upd_index = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         m_upd_br = 0; m_upd_taken = 0; m_upd_correct = 0; m_redirect = 0;
         m_upd_target = 0; m_redirect_pc = 0; m_br = 0; m_mis_cnt = 0; m_upd_index = 0;
      end else begin
         m_pop = ex_valid && (mq.size() > 0);
         m_mis = 1'b0;
         mh    = '0;
         if (m_pop) begin
            mh    = mq[0];
            m_mis = (ex_taken != mh.take) || (ex_taken && ex_target != mh.target);
         end
         m_acc      = fetch_push && (mq.size() < DEPTH || m_pop) && !m_mis;
         m_upd_br   = m_pop;
         m_redirect = m_mis;
         if (m_pop) begin
            m_upd_taken   = ex_taken;
            m_upd_correct = !m_mis;
            m_upd_target  = ex_target;
            m_upd_index   = mh.index;
            m_br          = m_br + 1;
            void'(mq.pop_front());
            if (m_mis) begin
               m_redirect_pc = ex_taken ? ex_target : mh.pc + 32'd4;
               m_mis_cnt     = m_mis_cnt + 1;
               mq.delete();
            end
         end
         if (m_acc) mq.push_back('{fetch_pc, fetch_take, fetch_target, fetch_index});
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      chk("q_full",      {31'd0, q_full},      {31'd0, mq.size() == DEPTH});
      chk("q_empty",     {31'd0, q_empty},     {31'd0, mq.size() == 0});
      chk("upd_br",      {31'd0, upd_br},      {31'd0, m_upd_br});
      chk("upd_taken",   {31'd0, upd_taken},   {31'd0, m_upd_taken});
      chk("upd_correct", {31'd0, upd_correct}, {31'd0, m_upd_correct});
      chk("upd_target",  upd_target,           m_upd_target);
      chk("upd_index",   {30'd0, upd_index},   {30'd0, m_upd_index});
      chk("redirect",    {31'd0, redirect},    {31'd0, m_redirect});
      chk("redirect_pc", redirect_pc,          m_redirect_pc);
      chk("stat_br",     stat_branches,        m_br);
      chk("stat_mis",    stat_mispredicts,     m_mis_cnt);
   end

   // One clock of stimulus; inputs change 1 time unit after the edge.
   task automatic step(input logic push, input logic [31:0] pc, input logic take,
                       input logic [31:0] tgt, input logic [1:0] idx,
                       input logic exv, input logic ext, input logic [31:0] extgt);
      fetch_push = push; fetch_pc = pc; fetch_take = take;
      fetch_target = tgt; fetch_index = idx;
      ex_valid = exv; ex_taken = ext; ex_target = extgt;
      @(posedge clk); #1;
      fetch_push = 0; ex_valid = 0;
   endtask

   task automatic push_only(input logic [31:0] pc, input logic take, input logic [31:0] tgt,
                            input logic [1:0] idx);
      step(1'b1, pc, take, tgt, idx, 1'b0, 1'b0, 32'h0);
   endtask

   task automatic pop_only(input logic ext, input logic [31:0] extgt);
      step(1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b1, ext, extgt);
   endtask

   int k;

   initial begin
      // Reset held with inputs toggling.
      for (int i = 0; i < 5; i++) begin
         fetch_push = 1'($urandom); fetch_pc = $urandom; fetch_take = 1'($urandom);
         fetch_target = $urandom; fetch_index = 2'($urandom);
         ex_valid = 1'($urandom); ex_taken = 1'($urandom); ex_target = $urandom;
         @(posedge clk); #1;
      end
      chk("rst_q_empty", {31'd0, q_empty}, 32'd1);
      chk("rst_upd_br",  {31'd0, upd_br},  32'd0);
      chk("rst_stat_br", stat_branches,    32'd0);
      fetch_push = 0; ex_valid = 0;
      rst_n = 1'b1;
      repeat (3) step(1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
      chk("idle_q_empty", {31'd0, q_empty}, 32'd1);

      // Correct predicted-taken.
      push_only(32'h100, 1'b1, 32'h200, 2'd0);
      chk("push_not_empty", {31'd0, q_empty}, 32'd0);
      pop_only(1'b1, 32'h200);
      chk("ct_upd_br",      {31'd0, upd_br},      32'd1);
      chk("ct_upd_correct", {31'd0, upd_correct}, 32'd1);
      chk("ct_upd_index",   {30'd0, upd_index},   32'd0);
      chk("ct_redirect",    {31'd0, redirect},    32'd0);
      chk("ct_stat_br",     stat_branches,        32'd1);

      // Not-taken mispredict flushes younger entries.
      push_only(32'h40, 1'b1, 32'h80, 2'd2);
      push_only(32'h50, 1'b0, 32'h0,  2'd1);
      push_only(32'h60, 1'b1, 32'h90, 2'd3);
      pop_only(1'b0, 32'h80);
      chk("nt_redirect",    {31'd0, redirect},    32'd1);
      chk("nt_redirect_pc", redirect_pc,          32'h44);
      chk("nt_upd_correct", {31'd0, upd_correct}, 32'd0);
      chk("nt_upd_taken",   {31'd0, upd_taken},   32'd0);
      chk("nt_upd_index",   {30'd0, upd_index},   32'd2);
      chk("nt_q_empty",     {31'd0, q_empty},     32'd1);
      chk("nt_stat_mis",    stat_mispredicts,     32'd1);
      step(1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
      chk("nt_redirect_off", {31'd0, redirect}, 32'd0);
      chk("nt_pc_hold",      redirect_pc,       32'h44);

      // Target mismatch.
      push_only(32'h70, 1'b1, 32'h300, 2'd1);
      pop_only(1'b1, 32'h304);
      chk("tm_redirect_pc", redirect_pc,     32'h304);
      chk("tm_upd_target",  upd_target,      32'h304);
      chk("tm_stat_mis",    stat_mispredicts, 32'd2);

      // Fill, drop, push+pop at full, and drain across pointer wrap.
      for (k = 0; k < DEPTH; k++)
         push_only(32'h1000 + 4 * k, k[0], 32'h2000 + 8 * k, 2'(k));
      chk("full_q_full", {31'd0, q_full}, 32'd1);
      push_only(32'hDEAD, 1'b0, 32'h0, 2'd3);
      chk("drop_q_full", {31'd0, q_full}, 32'd1);
      for (int j = 0; j < 2 * DEPTH; j++) begin
         step(1'b1, 32'h1000 + 4 * k, k[0], 32'h2000 + 8 * k, 2'(k),
              1'b1, j[0], j[0] ? 32'h2000 + 8 * j : 32'hFFFF0000);
         k++;
         chk("wrap_idx",    {30'd0, upd_index},   32'(j % 4));
         chk("wrap_full",   {31'd0, q_full},      32'd1);
         chk("wrap_correct",{31'd0, upd_correct}, 32'd1);
      end
      for (int j = 2 * DEPTH; j < 3 * DEPTH; j++) begin
         pop_only(j[0], j[0] ? 32'h2000 + 8 * j : 32'h0);
         chk("drain_idx", {30'd0, upd_index}, 32'(j % 4));
      end
      chk("drain_empty",   {31'd0, q_empty}, 32'd1);
      chk("drain_stat_br", stat_branches,    32'd15);

      // ex_valid on empty queue is ignored.
      pop_only(1'b0, 32'h0);
      chk("empty_pop_br",   {31'd0, upd_br},  32'd0);
      chk("empty_pop_stat", stat_branches,    32'd15);

      // Mispredict with simultaneous push: push discarded.
      push_only(32'h500, 1'b0, 32'h0, 2'd1);
      step(1'b1, 32'h520, 1'b1, 32'h700, 2'd2, 1'b1, 1'b1, 32'h600);
      chk("mp_redirect_pc", redirect_pc,      32'h600);
      chk("mp_q_empty",     {31'd0, q_empty}, 32'd1);
      step(1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
      chk("mp_still_empty", {31'd0, q_empty}, 32'd1);

      // Reset pulse with 3 in flight and a strobe pending.
      for (int j = 0; j < DEPTH; j++) push_only(32'h800 + 4 * j, 1'b0, 32'h0, 2'(j));
      pop_only(1'b0, 32'h0);
      chk("pre_rst_upd_br", {31'd0, upd_br}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_upd_br",  {31'd0, upd_br},  32'd0);
      chk("arst_q_empty", {31'd0, q_empty}, 32'd1);
      chk("arst_stat_br", stat_branches,    32'd0);
      chk("arst_pc",      redirect_pc,      32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) step(1'b0, 0, 0, 0, 0, 1'b0, 0, 0);
      chk("post_rst_empty", {31'd0, q_empty}, 32'd1);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
